// File: rtl/or_and_pkg.sv
// ---------------------------------------------------------------------------
// or_and_pkg
// Shared definitions for the OR-AND tree sweep engine and its golden model.
//   - levels(): number of reduction levels above the X&Y level (clog2 of N)
//   - isPow2(): power-of-two test used for parameter legality checks
//   - state_t : sweep FSM state encoding
// ---------------------------------------------------------------------------
package or_and_pkg;

    // Sweep engine states; the numeric values are fixed so that software
    // or a logic analyser can decode them directly.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of pairwise reduction levels needed to collapse n leaves to one.
    function automatic int levels(input int n);
        return $clog2(n);
    endfunction

    // True when n is a positive power of two.
    function automatic bit isPow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/or_and_model.sv
// ---------------------------------------------------------------------------
// or_and_model
// Combinational golden model of the OR-AND reduction tree.
// Ports:
//   X     in  N  first operand vector
//   Y     in  N  second operand vector
//   Z_exp out 1  expected tree output
// Level 0 is X&Y; each higher level pairs neighbours, odd levels with OR and
// even levels with AND, until one element remains.
// ---------------------------------------------------------------------------
module or_and_model
    import or_and_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic         Z_exp
);

    localparam int LEVELS = levels(N);

    // The whole tree is evaluated inside a function so the intermediate
    // levels live in local variables rather than in a self-referencing array.
    function automatic logic evalTree(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-1:0] cur;
        logic [N-1:0] nxt;
        cur = x & y;
        for (int k = 1; k <= LEVELS; k++) begin
            nxt = '0;
            for (int i = 0; i < (N >> k); i++) begin
                if ((k % 2) == 1)
                    nxt[i] = cur[2*i] | cur[2*i+1];
                else
                    nxt[i] = cur[2*i] & cur[2*i+1];
            end
            cur = nxt;
        end
        return cur[0];
    endfunction

    // Pure combinational evaluation of the current stimulus vector.
    always_comb begin
        Z_exp = evalTree(X, Y);
    end

endmodule

// File: rtl/or_and_tree_sweep.sv
// ---------------------------------------------------------------------------
// or_and_tree_sweep
// Exhaustive stimulus-and-check engine for an OR-AND reduction tree. Drives
// every (X, Y) combination, samples the tree's Z after LAT cycles and compares
// it against the internal golden model.
// Ports:
//   clk        in  1     clock, rising edge
//   rst_n      in  1     asynchronous active-low reset
//   start      in  1     begin a sweep (honoured in IDLE or DONE only)
//   abort      in  1     stop the sweep and return to IDLE
//   X_out      out N     stimulus X to the tree under test
//   Y_out      out N     stimulus Y to the tree under test
//   Z_in       in  1     result from the tree under test
//   busy       out 1     sweep in progress (RUN or DRAIN)
//   done       out 1     sweep finished
//   pass       out 1     finished with zero mismatches
//   err_count  out 2N+1  number of mismatching samples
//   fail_valid out 1     first_fail holds a captured failure
//   first_fail out 2N    vector index of the first mismatch
// ---------------------------------------------------------------------------
module or_and_tree_sweep
    import or_and_pkg::*;
#(
    parameter int N   = 8,
    parameter int LAT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    output logic [N-1:0]   X_out,
    output logic [N-1:0]   Y_out,
    input  logic           Z_in,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*N:0]   err_count,
    output logic           fail_valid,
    output logic [2*N-1:0] first_fail
);

    // Reject unsupported tree sizes and latencies at elaboration.
    if (!isPow2(N) || (N < 2) || (N > 8)) begin : g_bad_n
        $error("or_and_tree_sweep: N must be 2, 4 or 8");
    end
    if ((LAT < 0) || (LAT > 7)) begin : g_bad_lat
        $error("or_and_tree_sweep: LAT must be in 0..7");
    end

    localparam int VW = 2 * N;
    localparam logic [2:0] DRAIN_LOAD = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    state_t          state;
    logic [VW-1:0]   vec;
    logic [2:0]      drainCnt;
    logic            zExp;
    logic            sweepStart;
    logic            stage0Valid;
    logic            alignedValid;
    logic            alignedExp;
    logic [VW-1:0]   alignedIdx;

    // The stimulus outputs are simply the two halves of the vector counter,
    // so they are registered and naturally hold their value outside RUN.
    assign X_out = vec[N-1:0];
    assign Y_out = vec[VW-1:N];

    // A new sweep is accepted only from IDLE or DONE, and abort wins.
    assign sweepStart  = start && !abort && ((state == IDLE) || (state == DONE));
    assign stage0Valid = (state == RUN);
    assign pass        = done && (err_count == '0);

    or_and_model #(
        .N (N)
    ) u_model (
        .X     (X_out),
        .Y     (Y_out),
        .Z_exp (zExp)
    );

    // Sweep FSM with the vector counter, drain counter and the registered
    // busy/done flags. busy/done are updated on the same edge as the state
    // so they always match the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            vec      <= '0;
            drainCnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        vec   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (vec == '1) begin
                        if (LAT > 0) begin
                            state    <= DRAIN;
                            drainCnt <= DRAIN_LOAD;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        vec <= vec + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drainCnt == 3'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drainCnt <= drainCnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // The expected bit, its vector index and a valid flag travel through a
    // LAT-deep shift line so they meet Z_in on the edge the tree result is
    // due. With LAT=0 the comparison happens on the vector's own cycle.
    if (LAT == 0) begin : g_nodelay
        assign alignedValid = stage0Valid;
        assign alignedExp   = zExp;
        assign alignedIdx   = vec;
    end else begin : g_delay
        logic [LAT-1:0] vldSr;
        logic [LAT-1:0] expSr;
        logic [VW-1:0]  idxSr [LAT];

        // Shift line for expected samples. Abort flushes the valid bits so
        // nothing left in flight is compared during the next sweep.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vldSr <= '0;
                expSr <= '0;
                for (int i = 0; i < LAT; i++) idxSr[i] <= '0;
            end else begin
                for (int i = LAT - 1; i > 0; i--) begin
                    vldSr[i] <= vldSr[i-1];
                    expSr[i] <= expSr[i-1];
                    idxSr[i] <= idxSr[i-1];
                end
                vldSr[0] <= stage0Valid;
                expSr[0] <= zExp;
                idxSr[0] <= vec;
                if (abort) vldSr <= '0;
            end
        end

        assign alignedValid = vldSr[LAT-1];
        assign alignedExp   = expSr[LAT-1];
        assign alignedIdx   = idxSr[LAT-1];
    end

    // Error accumulator. A fresh sweep clears everything first; otherwise
    // every aligned mismatch bumps the count and the first one latches its
    // vector index. The counter is one bit wider than the vector index so
    // even an all-fail sweep cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else if (sweepStart) begin
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else if (alignedValid && (Z_in != alignedExp)) begin
            err_count <= err_count + 1'b1;
            if (!fail_valid) begin
                fail_valid <= 1'b1;
                first_fail <= alignedIdx;
            end
        end
    end

endmodule

// File: tb/tb_or_and_tree_sweep.sv
// ---------------------------------------------------------------------------
// tb_or_and_tree_sweep
// Self-checking bench for or_and_tree_sweep. One N=2/LAT=0 engine drives a
// behavioural tree whose output can be correct, stuck at 0 or inverted; two
// N=4 engines (LAT=2 and LAT=1) drive trees with two output registers.
// Expected vector indices go into a queue when a sweep is started and are
// popped as the engine drives them; final results come from the bench's own
// tree expressions.
// ---------------------------------------------------------------------------
module tb_or_and_tree_sweep;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // N=2, LAT=0 engine and its tree
    logic       start2 = 1'b0;
    logic       abort2 = 1'b0;
    logic [1:0] x2, y2;
    logic       z2;
    logic       busy2, done2, pass2, fv2;
    logic [4:0] err2;
    logic [3:0] ff2;
    int         zMode = 0;

    // N=4 engines sharing one start, LAT=2 and LAT=1
    logic       start4 = 1'b0;
    logic       abort4 = 1'b0;
    logic [3:0] x4, y4, x4b, y4b;
    logic       z4a = 1'b0, z4b = 1'b0, z4c = 1'b0, z4d = 1'b0;
    logic       busy4, done4, pass4, fv4;
    logic       busy4b, done4b, pass4b, fv4b;
    logic [8:0] err4, err4b;
    logic [7:0] ff4, ff4b;

    int total = 0;
    int bad   = 0;
    int expQ[$];

    always #5 clk = ~clk;

    // Reference trees written out explicitly per size.
    function automatic logic refTree2(input logic [1:0] x, input logic [1:0] y);
        return (x[0] & y[0]) | (x[1] & y[1]);
    endfunction

    function automatic logic refTree4(input logic [3:0] x, input logic [3:0] y);
        return ((x[0] & y[0]) | (x[1] & y[1])) & ((x[2] & y[2]) | (x[3] & y[3]));
    endfunction

    // Tree under test for the N=2 engine: 0 correct, 1 stuck at 0, 2 inverted.
    assign z2 = (zMode == 0) ? refTree2(x2, y2) :
                (zMode == 1) ? 1'b0 : ~refTree2(x2, y2);

    // Two-register pipelined trees for the N=4 engines.
    always @(posedge clk) begin
        z4a <= refTree4(x4, y4);
        z4b <= z4a;
        z4c <= refTree4(x4b, y4b);
        z4d <= z4c;
    end

    or_and_tree_sweep #(.N(2), .LAT(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .X_out(x2), .Y_out(y2), .Z_in(z2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err2), .fail_valid(fv2), .first_fail(ff2)
    );

    or_and_tree_sweep #(.N(4), .LAT(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .X_out(x4), .Y_out(y4), .Z_in(z4b), .busy(busy4), .done(done4),
        .pass(pass4), .err_count(err4), .fail_valid(fv4), .first_fail(ff4)
    );

    or_and_tree_sweep #(.N(4), .LAT(1)) dut4b (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .X_out(x4b), .Y_out(y4b), .Z_in(z4d), .busy(busy4b), .done(done4b),
        .pass(pass4b), .err_count(err4b), .fail_valid(fv4b), .first_fail(ff4b)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // One N=2 sweep. action: 0 plain, 1 extra start pulses during RUN,
    // 2 abort when vector 6 is on the outputs, 3 reset at vector 6.
    task automatic applyStimulus(input int mode, input int action);
        int   cycles;
        int   expErr;
        int   expFirst;
        bit   seenFail;
        int   expv;
        logic zr;
        logic zd;
        logic [3:0] vv;
        zMode    = mode;
        expErr   = 0;
        expFirst = 0;
        seenFail = 0;
        expQ.delete();
        for (int v = 0; v < 16; v++) begin
            vv = 4'(v);
            expQ.push_back(v);
            zr = refTree2(vv[1:0], vv[3:2]);
            zd = (mode == 0) ? zr : (mode == 1) ? 1'b0 : ~zr;
            if (zd != zr) begin
                expErr++;
                if (!seenFail) begin
                    seenFail = 1;
                    expFirst = v;
                end
            end
        end
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        checkOutput("busy_rise", busy2, 1);
        checkOutput("err_cleared", err2, 0);
        cycles = 0;
        while (busy2 && cycles < 40) begin
            if (expQ.size() > 0) begin
                expv = expQ.pop_front();
                checkOutput("vec2", {y2, x2}, expv);
            end else begin
                checkOutput("vec2_extra", 1, 0);
            end
            cycles++;
            start2 = (action == 1) && (cycles == 3 || cycles == 8);
            if (action == 2 && {y2, x2} == 4'd6) begin
                start2 = 1'b0;
                abort2 = 1'b1;
                @(negedge clk) abort2 = 1'b0;
                checkOutput("abort_busy", busy2, 0);
                checkOutput("abort_done", done2, 0);
                checkOutput("abort_pass", pass2, 0);
                checkOutput("abort_hold", {y2, x2}, 6);
                @(negedge clk);
                checkOutput("abort_stays_idle", busy2, 0);
                return;
            end
            if (action == 3 && {y2, x2} == 4'd6) begin
                rst_n = 1'b0;
                #1;
                checkOutput("rst_xy", {y2, x2}, 0);
                checkOutput("rst_busy", busy2, 0);
                checkOutput("rst_done", done2, 0);
                checkOutput("rst_pass", pass2, 0);
                checkOutput("rst_err", err2, 0);
                checkOutput("rst_fv", fv2, 0);
                checkOutput("rst_ff", ff2, 0);
                @(negedge clk) rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        start2 = 1'b0;
        checkOutput("busy_cycles2", cycles, 16);
        checkOutput("queue_drained2", expQ.size(), 0);
        checkOutput("done2", done2, 1);
        checkOutput("pass2", pass2, (expErr == 0) ? 1 : 0);
        checkOutput("err2", err2, expErr);
        checkOutput("fv2", fv2, (expErr != 0) ? 1 : 0);
        checkOutput("ff2", ff2, expFirst);
    endtask

    // Sweep of both N=4 engines with the two-register trees.
    task automatic runSweep4();
        int cycles;
        int expv;
        expQ.delete();
        for (int v = 0; v < 256; v++) expQ.push_back(v);
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        cycles = 0;
        while (busy4 && cycles < 300) begin
            if (cycles < 256) begin
                expv = expQ.pop_front();
                checkOutput("vec4", {y4, x4}, expv);
            end else begin
                checkOutput("vec4_hold", {y4, x4}, 255);
            end
            cycles++;
            @(negedge clk);
        end
        checkOutput("busy_cycles4", cycles, 258);
        checkOutput("done4", done4, 1);
        checkOutput("pass4", pass4, 1);
        checkOutput("err4", err4, 0);
        checkOutput("fv4", fv4, 0);
        checkOutput("done4b", done4b, 1);
        checkOutput("err4b_nonzero", (err4b != 0) ? 1 : 0, 1);
        checkOutput("pass4b", pass4b, 0);
        checkOutput("fv4b", fv4b, 1);
    endtask

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    // Main sequence.
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_xy", {y2, x2}, 0);
        checkOutput("reset_busy", busy2, 0);
        checkOutput("reset_done", done2, 0);
        checkOutput("reset_pass", pass2, 0);
        checkOutput("reset_err", err2, 0);
        checkOutput("reset_fv", fv2, 0);
        checkOutput("reset_ff", ff2, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_busy", busy2, 0);

        applyStimulus(0, 1);
        applyStimulus(1, 0);
        applyStimulus(2, 0);
        applyStimulus(0, 2);
        applyStimulus(0, 0);
        applyStimulus(0, 3);
        checkOutput("post_rst_busy", busy2, 0);
        applyStimulus(0, 0);

        runSweep4();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/or_and_tree_sweep.md
# or_and_tree_sweep

Sequential exhaustive stimulus-and-check engine for the OR-AND reduction tree. It drives every (X, Y) vector combination into a tree instance and samples the tree's Z output after a configurable latency. Each sample is compared against an internal golden model, and the engine reports mismatch count, first failing vector and pass/fail. It sits on the tree's input side as its driver, for board bring-up and self-test of combinational or pipelined tree variants.

## Interface
Parameters:
- N, 8: pairs per vector. Must be a power of 2 in {2,4,8}; elaboration error otherwise.
- LAT, 0: DUT latency in cycles from X/Y change to valid Z, range 0..7.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a sweep; ignored unless state is IDLE or DONE.
- abort  in  1  ends the sweep immediately and returns to IDLE.
- X_out  out  N  stimulus X to DUT (registered).
- Y_out  out  N  stimulus Y to DUT (registered).
- Z_in  in  1  DUT result.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  done && err_count==0.
- err_count  out  2N+1  number of mismatches (cannot overflow).
- fail_valid  out  1  a first failure has been captured.
- first_fail  out  2N  vector index of first mismatch.

## Operation
- Vector index v counts 0 .. V-1, where V = 2^(2N). X_out = v[N-1:0], Y_out = v[2N-1:N].
- Golden model:
  - Level 0: a = X & Y.
  - Level k ≥ 1 pairs elements 2i and 2i+1 of level k-1. Odd k uses OR; even k uses AND.
  - Z = single element of level log2(N).
  - Examples: N=2 gives Z=(x0y0)|(x1y1). N=4 gives Z=(a0|a1)&(a2|a3).
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start, go to RUN. Clear err_count, fail_valid and first_fail. Load v=0.
  - RUN: v increments each cycle. After vector V-1 is driven, go to DRAIN if LAT>0, else go to DONE.
  - DRAIN: stay LAT cycles, no new vectors, then go to DONE.
  - DONE: hold all results. start causes a fresh sweep exactly as from IDLE.
  - abort in RUN, DRAIN or DONE: go to IDLE next edge. Counters and results are kept; done=0, pass=0. abort has priority over start.
- Compare: the expected bit and index are delayed LAT stages, aligned with Z_in.
  - Each aligned valid sample with Z_in ≠ expected: err_count += 1.
  - On the first such sample: first_fail = index, fail_valid = 1.
- X_out/Y_out hold their last value outside RUN.

## Timing
- Reset values: X_out=0, Y_out=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0. State is IDLE; the delay line is invalid.
- start sampled at edge k:
  - Vector 0 appears on X_out/Y_out in cycle k+1; busy=1 from cycle k+1.
  - Vector v is driven in cycle k+1+v.
  - Z_in for vector v is sampled at the edge closing cycle k+1+v+LAT.
- busy is high for exactly V+LAT cycles. done rises in cycle k+1+V+LAT.
- Reset asserted mid-sweep: all outputs return to reset values asynchronously, and no partial results are kept.
- start while busy has no effect.
- Delay-line valid bits are cleared on abort, so stale samples are never compared on the next sweep.

## Structure
- Shared package or_and_pkg holds:
  - LEVELS function (clog2).
  - Power-of-2 check.
  - State encoding constants (IDLE=0, RUN=1, DRAIN=2, DONE=3).
- Sub-module or_and_model: combinational golden model with parameter N, inputs X/Y, output Z_exp. It is instantiated once.
- The top holds the FSM, vector counter, LAT-deep expected/index/valid delay line, and the error accumulator.

## Test plan
- N=2, LAT=0, Z_in from a correct combinational tree, start pulse -> busy 16 cycles, done=1, pass=1, err_count=0, fail_valid=0.
- N=2, LAT=0, Z_in tied 0 -> err_count=7, first_fail=5 (x0=y0=1), fail_valid=1, pass=0.
- N=2, LAT=0, Z_in = inverted correct tree -> err_count=16, first_fail=0.
- N=4, LAT=2, DUT with 2 output registers -> pass=1, busy 256+2 cycles. Same DUT with LAT=1 -> err_count>0.
- N=2 mid-sweep tests:
  - abort at v=6 -> IDLE next cycle, done=0, busy=0. A later start gives a clean pass.
  - Asserting rst_n=0 at v=6 -> all outputs 0 immediately.
- start pulses during RUN are ignored (the run finishes at the expected cycle). start in DONE re-runs and clears err_count to 0 first.
